// File: rtl/fmdll_pkg.sv
// Shared types for the FMDLL delay-line controller: FSM states, step directions, default code width.
// Pure declarations: no logic, no latency, no flow control.
package fmdll_pkg;

  localparam int CODE_W_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAR,
    ST_TRACK
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DN
  } dir_e;

endpackage

// File: rtl/fmdll_dly_ctrl_if.sv
// Control/status bundle between the delay-line controller (master) and the FMDLL top / phase detector (slave).
// Wires only: no latency; no backpressure, the phase detector decisions are level signals.
interface fmdll_dly_ctrl_if #(
  parameter int CODE_W = fmdll_pkg::CODE_W_DEF
);

  logic              en;
  logic              pd_up;
  logic              pd_dn;
  logic [CODE_W-1:0] dly_code;
  logic              locked;
  logic              sat;
  logic              busy;

  modport master (
    input  en,
    input  pd_up,
    input  pd_dn,
    output dly_code,
    output locked,
    output sat,
    output busy
  );

  modport slave (
    output en,
    output pd_up,
    output pd_dn,
    input  dly_code,
    input  locked,
    input  sat,
    input  busy
  );

endinterface

// File: rtl/fmdll_lock_mon.sv
// Lock monitor: counts quiet tracking windows (holds or reversals) and flags lock at LOCK_CNT.
// Latency: locked updates on the window-end edge; no backpressure, evaluated once per strobe.
module fmdll_lock_mon
  import fmdll_pkg::*;
#(
  parameter int LOCK_CNT = 8
) (
  input  logic CLK_exit,
  input  logic rst_n,
  input  logic clr,
  input  logic win_stb,
  input  dir_e step_dir,
  input  logic sat_evt,
  output logic locked
);

  localparam int                CNT_W    = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CNT);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  dir_e             prev_q, prev_d;
  logic             locked_q;

  assign cnt_inc = (cnt_q == LOCK_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // prev_q remembers the last real step; holds and saturated attempts leave it alone
  always_comb begin
    cnt_d  = cnt_q;
    prev_d = prev_q;
    if (clr) begin
      cnt_d  = '0;
      prev_d = DIR_NONE;
    end else if (win_stb) begin
      if (sat_evt) begin
        cnt_d = '0;
      end else if (step_dir == DIR_NONE) begin
        cnt_d = cnt_inc;
      end else begin
        if (step_dir == prev_q) begin
          cnt_d = '0;
        end else if (prev_q != DIR_NONE) begin
          cnt_d = cnt_inc;
        end
        prev_d = step_dir;
      end
    end
  end

  always_ff @(posedge CLK_exit or posedge rst_n) begin
    if (rst_n) begin
      cnt_q    <= '0;
      prev_q   <= DIR_NONE;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      locked_q <= (cnt_d == LOCK_MAX);
    end
  end

  assign locked = locked_q;

endmodule

// File: rtl/fmdll_dly_ctrl.sv
// FMDLL delay-code controller: SAR coarse search (FMDLL_SAR_EN) or linear search from mid-code, then +/-1 tracking.
// Latency: code moves once per SETTLE+1 cycle window; no backpressure, en low returns to IDLE next edge.
module fmdll_dly_ctrl
  import fmdll_pkg::*;
#(
  parameter int CODE_W   = CODE_W_DEF,
  parameter int SETTLE   = 3,
  parameter int LOCK_CNT = 8
) (
  input  logic                CLK_exit,
  input  logic                rst_n,
  fmdll_dly_ctrl_if.master    bus
);

  localparam int                 WIN_W    = $clog2(SETTLE + 1);
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(SETTLE);
  localparam logic [CODE_W-1:0] CODE_MID = CODE_W'(1) << (CODE_W - 1);
  localparam logic [CODE_W-1:0] CODE_MAX = '1;

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic              sat_q, sat_d;
  logic              win_end;
  logic              pd_inc, pd_dec;
  dir_e              step_dir;
  logic              sat_evt;
  logic              mon_clr;
  logic              mon_stb;

`ifdef FMDLL_SAR_EN
  localparam int BIT_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  logic [BIT_W-1:0] bit_q, bit_d;
`endif

  assign win_end = (win_q == WIN_LAST);
  assign pd_inc  = bus.pd_up & ~bus.pd_dn;
  assign pd_dec  = bus.pd_dn & ~bus.pd_up;

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    win_d    = win_q;
    sat_d    = sat_q;
`ifdef FMDLL_SAR_EN
    bit_d    = bit_q;
`endif
    step_dir = DIR_NONE;
    sat_evt  = 1'b0;
    mon_clr  = 1'b0;
    mon_stb  = 1'b0;
    // en low wins over any window end on the same edge: the code is frozen
    if (!bus.en) begin
      state_d = ST_IDLE;
      win_d   = '0;
      mon_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          code_d  = CODE_MID;
          sat_d   = 1'b0;
          win_d   = '0;
          mon_clr = 1'b1;
`ifdef FMDLL_SAR_EN
          state_d = ST_SAR;
          bit_d   = BIT_W'(CODE_W - 1);
`else
          state_d = ST_TRACK;
`endif
        end
`ifdef FMDLL_SAR_EN
        ST_SAR: begin
          if (win_end) begin
            win_d = '0;
            if (!pd_inc) begin
              code_d[bit_q] = 1'b0;
            end
            if (bit_q == '0) begin
              state_d = ST_TRACK;
            end else begin
              code_d[bit_q - BIT_W'(1)] = 1'b1;
              bit_d = bit_q - BIT_W'(1);
            end
          end else begin
            win_d = win_q + WIN_W'(1);
          end
        end
`endif
        ST_TRACK: begin
          if (win_end) begin
            win_d   = '0;
            mon_stb = 1'b1;
            if (pd_inc) begin
              if (code_q == CODE_MAX) begin
                sat_evt = 1'b1;
              end else begin
                code_d   = code_q + CODE_W'(1);
                step_dir = DIR_UP;
              end
            end else if (pd_dec) begin
              if (code_q == '0) begin
                sat_evt = 1'b1;
              end else begin
                code_d   = code_q - CODE_W'(1);
                step_dir = DIR_DN;
              end
            end
            if (sat_evt) begin
              sat_d = 1'b1;
            end
          end else begin
            win_d = win_q + WIN_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          win_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_exit or posedge rst_n) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      win_q   <= '0;
      sat_q   <= 1'b0;
`ifdef FMDLL_SAR_EN
      bit_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      win_q   <= win_d;
      sat_q   <= sat_d;
`ifdef FMDLL_SAR_EN
      bit_q   <= bit_d;
`endif
    end
  end

  fmdll_lock_mon #(
    .LOCK_CNT (LOCK_CNT)
  ) u_lock_mon (
    .CLK_exit (CLK_exit),
    .rst_n    (rst_n),
    .clr      (mon_clr),
    .win_stb  (mon_stb),
    .step_dir (step_dir),
    .sat_evt  (sat_evt),
    .locked   (bus.locked)
  );

  assign bus.dly_code = code_q;
  assign bus.sat      = sat_q;
  assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fmdll_dly_ctrl.sv
// Directed bench for fmdll_dly_ctrl (CODE_W=6, SETTLE=3, LOCK_CNT=4); PD model up=(code<up_lim), dn=(code>dn_lim).
// Cycle numbers below count edges after the en-rise (start) edge; outputs are sampled on the falling edge.
module tb_fmdll_dly_ctrl;

  logic CLK_exit;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   t      = 0;
  int   up_lim = 0;
  int   dn_lim = 0;

  fmdll_dly_ctrl_if #(.CODE_W(6)) bus ();

  fmdll_dly_ctrl #(
    .CODE_W   (6),
    .SETTLE   (3),
    .LOCK_CNT (4)
  ) dut (
    .CLK_exit (CLK_exit),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  initial begin
    CLK_exit = 1'b0;
    forever #5 CLK_exit = ~CLK_exit;
  end

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, t);
    end
  endtask

  task automatic pd_upd();
    bus.pd_up = (int'(bus.dly_code) < up_lim);
    bus.pd_dn = (int'(bus.dly_code) > dn_lim);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge CLK_exit);
      pd_upd();
    end
  endtask

  task automatic set_pd(input int up, input int dn);
    up_lim = up;
    dn_lim = dn;
    pd_upd();
  endtask

  task automatic start();
    bus.en = 1'b1;
    cyc(1);
    t = 0;
  endtask

  task automatic run_to(input int k);
    cyc(k - t);
    t = k;
  endtask

  task automatic stop();
    bus.en = 1'b0;
    cyc(2);
  endtask

  initial begin
    rst_n     = 1'b1;
    bus.en    = 1'b0;
    bus.pd_up = 1'b0;
    bus.pd_dn = 1'b0;
    cyc(2);
    chk("rst_code", bus.dly_code, 0);
    chk("rst_locked", bus.locked, 0);
    chk("rst_sat", bus.sat, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b0;
    cyc(2);
    chk("idle_code", bus.dly_code, 0);

    // Target 37: search, track to 37, then hold windows build lock.
    set_pd(37, 37);
    start();
    chk("t37_start_code", bus.dly_code, 32);
    chk("t37_start_busy", bus.busy, 1);
    run_to(2);
    chk("t37_midwin_hold", bus.dly_code, 32);
`ifdef FMDLL_SAR_EN
    run_to(4);  chk("sar_trial48", bus.dly_code, 48);
    run_to(8);  chk("sar_trial40", bus.dly_code, 40);
    run_to(12); chk("sar_trial36", bus.dly_code, 36);
    run_to(16); chk("sar_trial38", bus.dly_code, 38);
    run_to(20); chk("sar_trial37", bus.dly_code, 37);
    run_to(24); chk("sar_result", bus.dly_code, 36);
    run_to(28); chk("track_step37", bus.dly_code, 37);
    run_to(40); chk("t37_not_locked", bus.locked, 0);
    run_to(44); chk("t37_locked", bus.locked, 1);
`else
    run_to(4);  chk("lin_step33", bus.dly_code, 33);
    run_to(16); chk("lin_step36", bus.dly_code, 36);
    run_to(20); chk("lin_step37", bus.dly_code, 37);
    run_to(24); chk("lin_hold37", bus.dly_code, 37);
    run_to(32); chk("t37_not_locked", bus.locked, 0);
    run_to(36); chk("t37_locked", bus.locked, 1);
`endif
    chk("t37_code_locked", bus.dly_code, 37);

    // Asynchronous reset in the middle of a window, no clock edge in between.
    #2 rst_n = 1'b1;
    #1;
    chk("arst_code", bus.dly_code, 0);
    chk("arst_locked", bus.locked, 0);
    chk("arst_busy", bus.busy, 0);
    bus.en = 1'b0;
    cyc(1);
    rst_n = 1'b0;
    cyc(1);

    // Unreachable target: top-end saturation, lock never asserts.
    set_pd(70, 70);
    start();
`ifdef FMDLL_SAR_EN
    run_to(24); chk("sat_hi_sar_end", bus.dly_code, 63);
    chk("sat_hi_pre", bus.sat, 0);
    run_to(28);
    chk("sat_hi_flag", bus.sat, 1);
    chk("sat_hi_code", bus.dly_code, 63);
    run_to(60);
`else
    run_to(124); chk("sat_hi_lin_end", bus.dly_code, 63);
    chk("sat_hi_pre", bus.sat, 0);
    run_to(128);
    chk("sat_hi_flag", bus.sat, 1);
    chk("sat_hi_code", bus.dly_code, 63);
    run_to(160);
`endif
    chk("sat_hi_no_lock", bus.locked, 0);
    chk("sat_hi_sticky", bus.sat, 1);
    bus.en = 1'b0;
    cyc(3);
    chk("dis_busy", bus.busy, 0);
    chk("dis_code_held", bus.dly_code, 63);
    chk("dis_sat_kept", bus.sat, 1);

    // Re-enable clears sat and reloads mid-code; en then falls mid-search.
    set_pd(37, 37);
    start();
    chk("reen_code", bus.dly_code, 32);
    chk("reen_sat_clr", bus.sat, 0);
    run_to(9);
    bus.en = 1'b0;
    run_to(10);
    chk("enfall_busy", bus.busy, 0);
    chk("enfall_locked", bus.locked, 0);
`ifdef FMDLL_SAR_EN
    chk("enfall_code", bus.dly_code, 40);
    run_to(16);
    chk("enfall_code_held", bus.dly_code, 40);
`else
    chk("enfall_code", bus.dly_code, 34);
    run_to(16);
    chk("enfall_code_held", bus.dly_code, 34);
`endif
    cyc(2);

    // Always-down detector: bottom-end saturation.
    set_pd(0, -1);
    start();
`ifdef FMDLL_SAR_EN
    run_to(24);
`else
    run_to(128);
`endif
    chk("sat_lo_end", bus.dly_code, 0);
    chk("sat_lo_pre", bus.sat, 0);
    run_to(t + 4);
    chk("sat_lo_flag", bus.sat, 1);
    chk("sat_lo_code", bus.dly_code, 0);
    stop();

    // Dither around 20/21, then two forced up steps break lock.
    set_pd(21, 20);
    start();
`ifdef FMDLL_SAR_EN
    run_to(24); chk("dith_sar_res", bus.dly_code, 20);
    run_to(28); chk("dith_up", bus.dly_code, 21);
    run_to(32); chk("dith_dn", bus.dly_code, 20);
    run_to(40); chk("dith_not_locked", bus.locked, 0);
    run_to(44); chk("dith_locked", bus.locked, 1);
    chk("dith_lock_code", bus.dly_code, 21);
    run_to(48);
`else
    run_to(48); chk("dith_lin_reach", bus.dly_code, 20);
    run_to(52); chk("dith_up", bus.dly_code, 21);
    run_to(56); chk("dith_dn", bus.dly_code, 20);
    run_to(60); chk("dith_not_locked", bus.locked, 0);
    run_to(64); chk("dith_locked", bus.locked, 1);
`endif
    chk("dith_code20", bus.dly_code, 20);
    chk("dith_still_locked", bus.locked, 1);
    set_pd(64, 64);
    run_to(t + 4);
    chk("force_up1_code", bus.dly_code, 21);
    chk("force_up1_locked", bus.locked, 1);
    run_to(t + 4);
    chk("force_up2_code", bus.dly_code, 22);
    chk("force_up2_unlock", bus.locked, 0);
    stop();

`ifndef FMDLL_SAR_EN
    // Linear search from mid-code to 40, lock four windows later.
    set_pd(40, 40);
    start();
    run_to(28); chk("lin40_step39", bus.dly_code, 39);
    run_to(32); chk("lin40_reach", bus.dly_code, 40);
    run_to(44); chk("lin40_not_locked", bus.locked, 0);
    run_to(48); chk("lin40_locked", bus.locked, 1);
    stop();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmdll_dly_ctrl.md
# fmdll_dly_ctrl

Digital delay-line controller for the FMDLL. It sits directly upstream of the delay line: it consumes the phase detector's up/down decisions, which compare the delay-line output with the next `CLK_exit` edge, and drives the delay code. After enable it performs a binary (SAR) coarse search, then tracks ±1 LSB, and reports lock and saturation to the FMDLL top level.

## Interface
- `CODE_W`, default 6: delay-code width in bits.
- `SETTLE`, default 3: settle cycles after a code change before the phase detector is sampled. Must be ≥ 1.
- `LOCK_CNT`, default 8: number of consecutive "quiet" tracking windows required to assert `locked`. Must be ≥ 1.
- `CLK_exit`, input, 1: reference clock. All logic runs on its rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-high. The name is kept for codebase consistency; the polarity is high.
- `en`, input, 1: enable for the search and tracking loop.
- `pd_up`, input, 1: the line delay is too short, so the code must increase. Synchronous to `CLK_exit`.
- `pd_dn`, input, 1: the line delay is too long, so the code must decrease.
- `dly_code`, output, `CODE_W`: delay code to the delay line. Registered.
- `locked`, output, 1: the loop is locked. Registered.
- `sat`, output, 1: tracking tried to step past 0 or past 2^CODE_W−1. Sticky until the next start.
- `busy`, output, 1: high in the SAR and TRACK states.

## Operation
- **Reset values:** `dly_code`=0, `locked`=0, `sat`=0, `busy`=0. The state is IDLE and all counters are 0.
- **States:** IDLE, SAR, TRACK.
- **Windows:** a window is SETTLE+1 cycles. A code change takes effect at the window start. `pd_up`/`pd_dn` are sampled only on the last cycle of the window, and the resulting code is registered on that same edge, which also starts the next window.
- **Start (IDLE→SAR):** the first edge with `en`=1 sets `dly_code`=1<<(CODE_W−1), clears `sat`, clears the lock counter, and sets the bit index to CODE_W−1.
- **SAR, at each window end:**
  - The trial bit is kept iff `pd_up`=1 and `pd_dn`=0; otherwise it is cleared.
  - If lower bits remain, the next lower bit is set as the new trial.
  - After bit 0 is decided, go to TRACK.
  - Total SAR time is CODE_W windows.
- **TRACK, at each window end:**
  - `pd_up` only: code +1.
  - `pd_dn` only: code −1.
  - Both or neither: hold.
- **Saturation:** a +1 at max or a −1 at 0 holds the code and sets `sat`=1.
- **Lock counter:**
  - Increments (saturating at LOCK_CNT) on a hold window, or on a step opposite to the previous step.
  - Resets to 0 on a step in the same direction as the previous step, and on any saturation event.
  - `locked`=1 while the counter equals LOCK_CNT; it is re-evaluated every window.
- **`en` deasserted in any state:**
  - State goes to IDLE on the next edge, with `locked`=0 and `busy`=0.
  - `dly_code` holds its last value.
  - A later `en` rise restarts from the Start step.
- **Simultaneous events:** an `en` fall on a window-end edge takes priority; no code update occurs on that edge.
- **Arithmetic:** all code arithmetic is unsigned `CODE_W`-bit with explicit bounds checks. There is no wrap-around.

## Timing
- `dly_code` changes only on window-end edges, plus the Start edge.
- Latency from the `en` rise edge:
  - The SAR result is visible CODE_W×(SETTLE+1) cycles later.
  - The earliest `locked` is (CODE_W+LOCK_CNT)×(SETTLE+1) cycles later.
- Asynchronous reset clears all outputs immediately, including in the middle of a window or during SAR.
- `pd_up`/`pd_dn` are ignored outside sample cycles and in IDLE.

## Configuration
- **`FMDLL_SAR_EN` defined:** behaviour is exactly as above.
- **`FMDLL_SAR_EN` undefined:**
  - The SAR state and bit-index logic are removed.
  - Start loads `dly_code`=1<<(CODE_W−1) and enters TRACK directly.
  - The lock search is linear from mid-code.

## Structure
- **`fmdll_pkg`:**
  - the state enum (IDLE/SAR/TRACK);
  - the step-direction enum (NONE/UP/DN);
  - the default `CODE_W`.
- **Sub-module `fmdll_lock_mon`:**
  - Inputs: `CLK_exit`, `rst_n`, clear, window-end strobe, step direction and saturation event.
  - Outputs: `locked`.
  - Contains the previous-direction register and the lock counter.
- The window counter and FSM stay in `fmdll_dly_ctrl`.

## Test plan
Bench settings: CODE_W=6, SETTLE=3, LOCK_CNT=4. The PD model is `pd_up`=(code<T) and `pd_dn`=(code>T), where T is the target code.

- **SAR search, T=37, SAR enabled:**
  - Trials are 32, 48, 40, 36, 38, 37.
  - The SAR result is 36 at cycle 24 after `en`.
  - The first TRACK window steps to 37.
  - `locked`=1 after 4 hold windows (cycle 44).
- **Saturation, T=70 (unreachable):**
  - SAR ends at 63.
  - TRACK up-steps saturate: `sat`=1 and the code stays at 63.
  - `locked` never asserts.
- **Dither, PD toggling up/dn every window around 20:**
  - The code alternates 20/21.
  - `locked` asserts after 4 windows.
  - Two consecutive up steps drop `locked` at that window end.
- **`en` falls mid-SAR at cycle 10:**
  - Code holds, `busy`=0, `locked`=0.
  - On re-enable the code reloads to 32 and `sat` clears.
- **Async reset during TRACK with code=37 and `locked`=1:**
  - `dly_code`=0, `locked`=0 and `busy`=0 immediately, without waiting for a clock edge.
- **`FMDLL_SAR_EN` undefined, T=40:**
  - Code goes 32→40 in 8 windows.
  - `locked` asserts 4 windows later.
